// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bundle for one mem_arbiter requester port.
// The requester holds req, we, addr and wdata stable until it sees ack.
`timescale 1ns/1ps
interface mem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 16
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port word-addressed memory.
// Each transaction takes IDLE -> ACCESS -> RESP, with ack in RESP.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_arbiter_if.slave          p0,
    mem_arbiter_if.slave          p1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  grant
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_start;
    logic                    w_sel;
    logic                    r_ptr;
    logic                    r_grant;
    logic                    r_wr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata0;
    logic [DATA_WIDTH-1:0]   r_rdata1;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_sel   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (p0.req || p1.req) begin
                    w_start = 1'b1;
                    w_next  = S_ACCESS;
                    // Contention goes to the pointer, else the lone requester.
                    w_sel   = (p0.req && p1.req) ? r_ptr : p1.req;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= 1'b0;
            r_grant  <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_start) begin
                r_grant <= w_sel;
                r_addr  <= w_sel ? p1.addr  : p0.addr;
                r_wr    <= w_sel ? p1.we    : p0.we;
                r_wdata <= w_sel ? p1.wdata : p0.wdata;
            end
            if (r_state == S_ACCESS) begin
                r_wr <= 1'b0;
                if (!r_wr) begin
                    if (r_grant) r_rdata1 <= mem_data;
                    else         r_rdata0 <= mem_data;
                end
            end
            if (r_state == S_RESP) r_ptr <= ~r_grant;
        end
    end

    // Registered strobe keeps our driver and the memory's apart.
    assign mem_data = r_wr ? r_wdata : 'z;
    assign mem_addr = r_addr;
    assign mem_wr   = r_wr;
    assign busy     = (r_state != S_IDLE);
    assign grant    = r_grant;
    assign p0.ack   = (r_state == S_RESP) && !r_grant;
    assign p1.ack   = (r_state == S_RESP) &&  r_grant;
    assign p0.rdata = r_rdata0;
    assign p1.rdata = r_rdata1;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, then random
// two-requester traffic against a word-level memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DW(32), .AW(16)) p0 ();
    mem_arbiter_if #(.DW(32), .AW(16)) p1 ();

    logic [15:0] mem_addr;
    logic        mem_wr;
    wire  [31:0] mem_data;
    logic        busy;
    logic        grant;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .p0       (p0),
        .p1       (p1),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_data (mem_data),
        .busy     (busy),
        .grant    (grant)
    );

    logic [1:0]  t_req;
    logic [1:0]  t_we;
    logic [15:0] t_addr [2];
    logic [31:0] t_wd   [2];
    logic [1:0]  ack;
    logic [31:0] rdata  [2];

    assign p0.req   = t_req[0];
    assign p0.we    = t_we[0];
    assign p0.addr  = t_addr[0];
    assign p0.wdata = t_wd[0];
    assign p1.req   = t_req[1];
    assign p1.we    = t_we[1];
    assign p1.addr  = t_addr[1];
    assign p1.wdata = t_wd[1];
    assign ack      = {p1.ack, p0.ack};
    assign rdata[0] = p0.rdata;
    assign rdata[1] = p1.rdata;

    // Memory with switch input at 0xFFE0 and display digit 0 at 0xFFF0.
    logic [31:0] mem [0:65535];
    logic [3:0]  sw;
    logic [3:0]  digit0;
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [31:0] pl_data;
    logic [31:0] w_mrd;

    always_comb w_mrd = (mem_addr == 16'hFFE0) ? {28'd0, sw} : mem[mem_addr];
    assign mem_data = mem_wr ? 32'bz : w_mrd;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_wr) begin
            mem[mem_addr] <= mem_data;
            if (mem_addr == 16'hFFF0) digit0 <= mem_data[3:0];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_mem [16];
    logic [1:0]  done;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [15:0] a, input logic [31:0] d);
        t_req[p]  = r;
        t_we[p]   = w;
        t_addr[p] = a;
        t_wd[p]   = d;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic wait_ack(input int p, output int lat);
        lat = 0;
        @(negedge clk);
        while (!ack[p] && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        if (!ack[p]) chk("ack timeout", 64'd0, 64'd1);
    endtask

    task automatic xfer(input int p, input logic w,
                        input logic [15:0] a, input logic [31:0] d);
        int lat;
        drive(p, 1'b1, w, a, d);
        wait_ack(p, lat);
        tick();
        t_req[p] = 1'b0;
    endtask

    task automatic requester(input int p);
        int lat;
        int gap;
        logic w;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] pre;
        for (int i = 0; i < 40; i++) begin
            w   = 1'($urandom_range(0, 1));
            a   = 16'h0100 + 16'($urandom_range(0, 15));
            d   = $urandom;
            pre = rdata[p];
            drive(p, 1'b1, w, a, d);
            wait_ack(p, lat);
            chk("rr latency", 64'(lat <= 5), 64'd1);
            if (w) begin
                chk("wr keeps rdata", rdata[p], pre);
                exp_mem[a[3:0]] = d;
            end else begin
                chk("rd data", rdata[p], exp_mem[a[3:0]]);
            end
            tick();
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                t_req[p] = 1'b0;
                repeat (gap) tick();
            end
        end
        t_req[p] = 1'b0;
        done[p]  = 1'b1;
    endtask

    task automatic monitor();
        logic [31:0] prv [2];
        prv[0] = rdata[0];
        prv[1] = rdata[1];
        while (done != 2'b11) begin
            @(negedge clk);
            chk("single ack", 64'(ack[0] & ack[1]), 64'd0);
            if (!ack[0]) chk("p0 rdata hold", rdata[0], prv[0]);
            if (!ack[1]) chk("p1 rdata hold", rdata[1], prv[1]);
            prv[0] = rdata[0];
            prv[1] = rdata[1];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acyc [$];
        int aprt [$];
        logic [31:0] rv [2];
        t_req  = '0;
        t_we   = '0;
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        done   = '0;
        sw     = 4'h0;
        pl_en  = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        reset  = 1'b1;
        repeat (2) tick();
        preload(16'h0010, 32'hDEADBEEF);
        preload(16'h0001, 32'h11111111);
        preload(16'h0002, 32'h22222222);
        reset = 1'b0;

        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst grant", grant, 0);
        chk("rst mem_wr", mem_wr, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst acks", ack, 0);
        chk("rst p0 rdata", rdata[0], 0);
        chk("rst p1 rdata", rdata[1], 0);

        // Single read with exact cycle timing.
        tick();
        drive(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        @(negedge clk);
        chk("rd N busy", busy, 0);
        @(negedge clk);
        chk("rd N+1 addr", mem_addr, 16'h0010);
        chk("rd N+1 busy", busy, 1);
        chk("rd N+1 ack", ack, 0);
        @(negedge clk);
        chk("rd N+2 ack", ack, 2'b01);
        chk("rd N+2 rdata", rdata[0], 32'hDEADBEEF);
        tick();
        t_req[0] = 1'b0;
        @(negedge clk);
        chk("rd N+3 busy", busy, 0);
        chk("rd N+3 ack", ack, 0);

        // Port 1 write then read back.
        tick();
        drive(1, 1'b1, 1'b1, 16'h0042, 32'h12345678);
        @(negedge clk);
        chk("wr N mem_wr", mem_wr, 0);
        @(negedge clk);
        chk("wr N+1 mem_wr", mem_wr, 1);
        chk("wr N+1 addr", mem_addr, 16'h0042);
        chk("wr N+1 data", mem_data, 32'h12345678);
        chk("wr N+1 grant", grant, 1);
        @(negedge clk);
        chk("wr N+2 mem_wr", mem_wr, 0);
        chk("wr N+2 ack", ack, 2'b10);
        chk("wr keeps p1 rdata", rdata[1], 0);
        tick();
        t_req[1] = 1'b0;
        tick();
        xfer(1, 1'b0, 16'h0042, 32'h0);
        chk("wr/rd p1 rdata", rdata[1], 32'h12345678);
        chk("wr/rd p0 rdata", rdata[0], 32'hDEADBEEF);

        // Both ports requesting continuously after reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 16'h0001, 32'h0);
        drive(1, 1'b1, 1'b0, 16'h0002, 32'h0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack[0] && ack[1]) chk("both acks", ack, 2'b00);
            else if (ack != 2'b00) begin
                acyc.push_back(k);
                aprt.push_back(ack[1] ? 1 : 0);
            end
        end
        rv[0] = rdata[0];
        rv[1] = rdata[1];
        tick();
        t_req = '0;
        chk("alt ack count", acyc.size(), 4);
        for (int j = 0; j < 4 && j < acyc.size(); j++) begin
            chk("alt ack cycle", acyc[j], 2 + 3 * j);
            chk("alt ack port", aprt[j], j % 2);
        end
        chk("alt p0 rdata", rv[0], 32'h11111111);
        chk("alt p1 rdata", rv[1], 32'h22222222);

        // Memory-mapped display write and switch read.
        tick();
        drive(1, 1'b1, 1'b1, 16'hFFF0, 32'h5);
        @(negedge clk);
        @(negedge clk);
        chk("io wr addr", mem_addr, 16'hFFF0);
        chk("io wr data", mem_data, 32'h5);
        chk("io wr strobe", mem_wr, 1);
        @(negedge clk);
        chk("io wr ack", ack, 2'b10);
        tick();
        t_req[1] = 1'b0;
        tick();
        chk("io digit0", digit0, 4'h5);
        sw = 4'hA;
        xfer(0, 1'b0, 16'hFFE0, 32'h0);
        chk("io sw read", rdata[0], 32'h0000000A);

        // Reset lands on the edge ending ACCESS of a port 0 read.
        tick();
        drive(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        @(negedge clk);
        tick();
        chk("abort in access", busy, 1);
        reset = 1'b1;
        t_req[0] = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort ack", ack, 0);
        chk("abort busy", busy, 0);
        chk("abort mem_wr", mem_wr, 0);
        chk("abort addr", mem_addr, 0);
        chk("abort grant", grant, 0);
        chk("abort p0 rdata", rdata[0], 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort no ack", ack, 0);
        end
        tick();
        xfer(1, 1'b0, 16'h0010, 32'h0);
        chk("post abort grant", grant, 1);
        chk("post abort rdata", rdata[1], 32'hDEADBEEF);

        // Quiet bus.
        repeat (10) begin
            @(negedge clk);
            chk("idle bus", {mem_wr, busy, ack}, 4'b0000);
        end

        // Random traffic from both requesters.
        tick();
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = $urandom;
            preload(16'h0100 + 16'(i), exp_mem[i]);
        end
        fork
            requester(0);
            requester(1);
            monitor();
        join

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
